// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Bundles the CPU data port, the loader write port and the status/statistics
// outputs of data_mem_responder.
//
//   CPU side     : data_adr, data_wdata, mem_read, mem_write  (to memory)
//                  data_rdata                                  (from memory)
//   Loader side  : ld_valid, ld_adr, ld_data                   (to memory)
//                  ld_ready                                    (from memory)
//   Status       : wb_count, align_err, proto_err, rd_cnt, wr_cnt
//
// Loader handshake: a loader write transfers on a rising clk edge exactly when
// ld_valid and ld_ready are both high in the cycle before that edge. ld_ready
// never depends on ld_valid. A write is not taken while ld_ready is low, and
// the loader may hold or change its request freely in that case.
//
// modport master : the requester (CPU + loader, or a testbench)
// modport slave  : the memory (data_mem_responder)
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic [31:0] data_adr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_adr;
  logic [31:0] ld_data;
  logic [1:0]  wb_count;
  logic        align_err;
  logic        proto_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  modport master (
    output data_adr, data_wdata, mem_read, mem_write,
    output ld_valid, ld_adr, ld_data,
    input  data_rdata, ld_ready, wb_count, align_err, proto_err,
    input  rd_cnt, wr_cnt
  );

  modport slave (
    input  data_adr, data_wdata, mem_read, mem_write,
    input  ld_valid, ld_adr, ld_data,
    output data_rdata, ld_ready, wb_count, align_err, proto_err,
    output rd_cnt, wr_cnt
  );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-port word memory for a CPU data port, with a 2-entry posted-write
// buffer so CPU stores never stall, and a loader write port with a
// valid/ready handshake.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (buffer, flags and counters only;
//          the array contents are kept)
//   bus  : data_mem_responder_if.slave (CPU port, loader port, status)
//
// Parameter:
//   DEPTH_WORDS : number of 32-bit words, power of two
//
// Optional build macro:
//   DMEM_STATS_EN : when defined, rd_cnt counts aligned read cycles and wr_cnt
//                   counts buffer enqueues, both saturating at 16'hFFFF.
//                   When undefined both outputs are constant zero.
//
// Array port arbitration, one access per cycle:
//   CPU read > drain (buffer full) > loader write > drain (buffer not empty)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Storage. No reset: contents survive rst.
  logic [31:0] r_mem [DEPTH_WORDS];

  // Posted-write buffer kept compacted: slot0 is the oldest entry, slot1 the
  // younger. Slots [0 .. r_cnt-1] are valid.
  logic [1:0]    r_cnt;
  logic [AW-1:0] r_idx0;
  logic [AW-1:0] r_idx1;
  logic [31:0]   r_dat0;
  logic [31:0]   r_dat1;

  logic          r_align_err;
  logic          r_proto_err;

  logic [AW-1:0] w_cpu_idx;
  logic [AW-1:0] w_ld_idx;
  logic          w_cpu_aligned;
  logic          w_rd_ok;
  logic          w_enq;
  logic          w_ld_ready;
  logic          w_ld_acc;
  logic          w_drain;
  logic [31:0]   w_rdata;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_widx;
  logic [31:0]   w_mem_wdat;

  logic [1:0]    w_kcnt;
  logic [AW-1:0] w_kidx0;
  logic [AW-1:0] w_kidx1;
  logic [31:0]   w_kdat0;
  logic [31:0]   w_kdat1;
  logic          w_keep0;
  logic          w_keep1;
  logic [1:0]    w_ncnt;
  logic [AW-1:0] w_nidx0;
  logic [AW-1:0] w_nidx1;
  logic [31:0]   w_ndat0;
  logic [31:0]   w_ndat1;

  // Address bits outside the decoded word index are ignored by design.
  logic          w_unused_adr;

  assign w_cpu_idx     = bus.data_adr[AW+1:2];
  assign w_ld_idx      = bus.ld_adr[AW+1:2];
  assign w_cpu_aligned = (bus.data_adr[1:0] == 2'b00);
  assign w_unused_adr  = ^{bus.data_adr[31:AW+2], bus.ld_adr[31:AW+2], bus.ld_adr[1:0]};

  assign w_rd_ok    = bus.mem_read && w_cpu_aligned;
  // Simultaneous read+write is a read; the write half is dropped.
  assign w_enq      = !rst && bus.mem_write && !bus.mem_read && w_cpu_aligned;
  assign w_ld_ready = !rst && !bus.mem_read && (r_cnt != 2'd2);
  assign w_ld_acc   = w_ld_ready && bus.ld_valid;
  // A full buffer always drains when the CPU is not reading; this is what
  // keeps occupancy at or below two, since an enqueue needs mem_read low.
  assign w_drain    = !rst && !bus.mem_read &&
                      ((r_cnt == 2'd2) || (!w_ld_acc && (r_cnt != 2'd0)));

  // Load data: youngest matching buffered store wins over the array.
  always_comb begin
    w_rdata = '0;
    if (w_rd_ok) begin
      if ((r_cnt == 2'd2) && (r_idx1 == w_cpu_idx)) begin
        w_rdata = r_dat1;
      end else if ((r_cnt != 2'd0) && (r_idx0 == w_cpu_idx)) begin
        w_rdata = r_dat0;
      end else begin
        w_rdata = r_mem[w_cpu_idx];
      end
    end
  end

  // Single array write port: drain and loader are mutually exclusive.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_widx = r_idx0;
    w_mem_wdat = r_dat0;
    if (w_drain) begin
      w_mem_we = 1'b1;
    end else if (w_ld_acc) begin
      w_mem_we   = 1'b1;
      w_mem_widx = w_ld_idx;
      w_mem_wdat = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_widx] <= w_mem_wdat;
    end
  end

  // Buffer next state: first remove the drained head or entries superseded
  // by a loader write, then append the CPU store. The CPU store is appended
  // after invalidation, so a same-cycle CPU store to the loader's index
  // survives and later overwrites the loader data.
  always_comb begin
    w_kcnt  = r_cnt;
    w_kidx0 = r_idx0;
    w_kdat0 = r_dat0;
    w_kidx1 = r_idx1;
    w_kdat1 = r_dat1;
    w_keep0 = 1'b0;
    w_keep1 = 1'b0;
    if (w_drain) begin
      w_kidx0 = r_idx1;
      w_kdat0 = r_dat1;
      w_kcnt  = r_cnt - 2'd1;
    end else if (w_ld_acc) begin
      w_keep0 = (r_cnt != 2'd0) && (r_idx0 != w_ld_idx);
      w_keep1 = (r_cnt == 2'd2) && (r_idx1 != w_ld_idx);
      case ({w_keep1, w_keep0})
        2'b00:   w_kcnt = 2'd0;
        2'b01:   w_kcnt = 2'd1;
        2'b10: begin
          w_kidx0 = r_idx1;
          w_kdat0 = r_dat1;
          w_kcnt  = 2'd1;
        end
        default: w_kcnt = 2'd2;
      endcase
    end

    w_ncnt  = w_kcnt;
    w_nidx0 = w_kidx0;
    w_ndat0 = w_kdat0;
    w_nidx1 = w_kidx1;
    w_ndat1 = w_kdat1;
    if (w_enq) begin
      w_ncnt = w_kcnt + 2'd1;
      if (w_kcnt == 2'd0) begin
        w_nidx0 = w_cpu_idx;
        w_ndat0 = bus.data_wdata;
      end else begin
        w_nidx1 = w_cpu_idx;
        w_ndat1 = bus.data_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_idx0      <= '0;
      r_idx1      <= '0;
      r_dat0      <= '0;
      r_dat1      <= '0;
      r_align_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_cnt  <= w_ncnt;
      r_idx0 <= w_nidx0;
      r_idx1 <= w_nidx1;
      r_dat0 <= w_ndat0;
      r_dat1 <= w_ndat1;
      if ((bus.mem_read || bus.mem_write) && !w_cpu_aligned) begin
        r_align_err <= 1'b1;
      end
      if (bus.mem_read && bus.mem_write) begin
        r_proto_err <= 1'b1;
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else begin
      if (w_rd_ok && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_enq && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign bus.rd_cnt = r_rd_cnt;
  assign bus.wr_cnt = r_wr_cnt;
`else
  assign bus.rd_cnt = 16'd0;
  assign bus.wr_cnt = 16'd0;
`endif

  assign bus.data_rdata = w_rdata;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.wb_count   = r_cnt;
  assign bus.align_err  = r_align_err;
  assign bus.proto_err  = r_proto_err;

endmodule
